index_register_file: RTL

//   Parametrised bank of CPU index registers (X, Y by default) with load, increment,

---
 rtl/index_register_file.sv | 122 ++++++++++++
 1 files changed

// File: rtl/index_register_file.sv
// Bank of index registers with load/inc/dec/transfer, registered N/Z flags
// and a registered base+index address add with page-cross carry.
module index_register_file #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 2,
    parameter int SELW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             resb,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [SELW-1:0]  dst_sel,
    input  logic [SELW-1:0]  src_sel,
    input  logic [WIDTH-1:0] db_in,
    input  logic [SELW-1:0]  rd_sel,
    output logic [WIDTH-1:0] db_out,
    output logic             flag_valid,
    output logic             flag_n,
    output logic             flag_z,
    output logic             op_err,
    input  logic             addr_req,
    input  logic [WIDTH-1:0] addr_base,
    input  logic [SELW-1:0]  addr_sel,
    output logic [WIDTH-1:0] addr_out,
    output logic             addr_carry,
    output logic             addr_valid
);

    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_XFER = 3'd4;

    localparam logic [SELW:0] NREG = (SELW+1)'(NUM_REGS);

    logic [WIDTH-1:0] regs [NUM_REGS];

    logic [WIDTH-1:0] dst_val;
    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] idx_val;
    logic [WIDTH-1:0] result;
    logic [WIDTH:0]   sum;
    logic             op_acc;
    logic             dst_oor;
    logic             src_oor;
    logic             op_bad;
    logic             wr_en;

    // Read muxes; an unmatched select reads 0 (db_out) or falls back to reg 0 (address index).
    always_comb begin
        db_out  = '0;
        dst_val = '0;
        src_val = '0;
        idx_val = regs[0];
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel == SELW'(i))   db_out  = regs[i];
            if (dst_sel == SELW'(i))  dst_val = regs[i];
            if (src_sel == SELW'(i))  src_val = regs[i];
            if (addr_sel == SELW'(i)) idx_val = regs[i];
        end
    end

    assign op_acc  = op_valid && (op == OP_LOAD || op == OP_INC || op == OP_DEC || op == OP_XFER);
    assign dst_oor = {1'b0, dst_sel} >= NREG;
    assign src_oor = {1'b0, src_sel} >= NREG;
    assign op_bad  = dst_oor || (op == OP_XFER && src_oor);
    assign wr_en   = op_acc && !op_bad;
    assign sum     = {1'b0, addr_base} + {1'b0, idx_val};

    always_comb begin
        result = '0;
        case (op)
            OP_LOAD: result = db_in;
            OP_INC:  result = dst_val + WIDTH'(1);
            OP_DEC:  result = dst_val - WIDTH'(1);
            OP_XFER: result = src_val;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (dst_sel == SELW'(i)) regs[i] <= result;
            end
        end
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            flag_valid <= 1'b0;
            flag_n     <= 1'b0;
            flag_z     <= 1'b1;
            op_err     <= 1'b0;
        end else begin
            flag_valid <= wr_en;
            op_err     <= op_acc && op_bad;
            if (wr_en) begin
                flag_n <= result[WIDTH-1];
                flag_z <= (result == '0);
            end
        end
    end

    // The add sees the pre-edge register value even when an op writes the same register.
    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            addr_out   <= '0;
            addr_carry <= 1'b0;
            addr_valid <= 1'b0;
        end else begin
            addr_valid <= addr_req;
            if (addr_req) begin
                addr_out   <= sum[WIDTH-1:0];
                addr_carry <= sum[WIDTH];
            end
        end
    end

endmodule
